// File: rtl/fir_output_decimator.sv
// FIR output decimator: keeps every DECIM-th accepted sample, narrows it to OUT_WIDTH, and buffers it in a FIFO.
// Optional build macro FIR_DECIM_ROUND_EN selects round-half-up with saturation instead of floor truncation.
module fir_output_decimator #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_en,
  input  logic signed [DATA_WIDTH-1:0]        iv_din,
  input  logic                                i_din_valid,
  output logic signed [OUT_WIDTH-1:0]         ov_dout,
  output logic                                o_dout_valid,
  input  logic                                i_dout_ready,
  output logic                                o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]         ov_level
);

  localparam int unsigned SHIFT = DATA_WIDTH - OUT_WIDTH;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned PW    = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [OUT_WIDTH-1:0] conv_c;

`ifdef FIR_DECIM_ROUND_EN
  localparam logic [DATA_WIDTH:0] RND_HALF = (DATA_WIDTH + 1)'(1) << (SHIFT - 1);
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  logic [DATA_WIDTH:0] rnd_sum_c;
  logic [OUT_WIDTH:0]  rnd_shift_c;

  // Round half up in one extra bit of headroom, then clamp if the top two bits disagree.
  always_comb begin
    rnd_sum_c   = {iv_din[DATA_WIDTH-1], iv_din} + RND_HALF;
    rnd_shift_c = rnd_sum_c[DATA_WIDTH:SHIFT];
    conv_c      = rnd_shift_c[OUT_WIDTH-1:0];
    if (rnd_shift_c[OUT_WIDTH] != rnd_shift_c[OUT_WIDTH-1]) begin
      conv_c = rnd_shift_c[OUT_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  // Dropping the LSBs of a two's-complement value is a floor arithmetic shift.
  always_comb begin
    conv_c = iv_din[DATA_WIDTH-1:SHIFT];
  end
`endif

  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        rd_ptr_nxt;
  logic [PW-1:0]        phase;
  logic                 accept_c;
  logic                 keep_c;
  logic                 pop_c;
  logic                 full_c;
  logic                 wr_c;
  logic                 drop_c;
  logic [LW-1:0]        level_after_pop;
  logic [LW-1:0]        level_nxt;
  logic [OUT_WIDTH-1:0] head_nxt;

  // Write/pop decisions and the head value the output register loads next.
  always_comb begin
    accept_c        = i_en & i_din_valid;
    keep_c          = accept_c & (phase == '0);
    pop_c           = o_dout_valid & i_dout_ready;
    full_c          = (ov_level == LW'(FIFO_DEPTH));
    wr_c            = keep_c & (~full_c | pop_c);
    drop_c          = keep_c & full_c & ~pop_c;
    rd_ptr_nxt      = rd_ptr + AW'(pop_c);
    level_after_pop = ov_level - LW'(pop_c);
    level_nxt       = level_after_pop + LW'(wr_c);
    // A write into an otherwise empty FIFO becomes the head directly (bypass).
    head_nxt        = (wr_c && (level_after_pop == '0)) ? conv_c : mem[rd_ptr_nxt];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      phase        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ov_level     <= '0;
      o_dout_valid <= 1'b0;
      o_overflow   <= 1'b0;
      ov_dout      <= '0;
    end else begin
      if (accept_c) begin
        phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + PW'(1);
      end
      if (wr_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (drop_c) begin
        o_overflow <= 1'b1;
      end
      rd_ptr       <= rd_ptr_nxt;
      ov_level     <= level_nxt;
      o_dout_valid <= (level_nxt != '0);
      ov_dout      <= head_nxt;
    end
  end

  // Storage array; contents are discarded logically by the pointer reset.
  always_ff @(posedge i_clk) begin
    if (wr_c && !i_rst) begin
      mem[wr_ptr] <= conv_c;
    end
  end

endmodule

// File: tb/tb_fir_output_decimator.sv
// Self-checking bench for fir_output_decimator (default parameters) with a queue-based reference model.
module tb_fir_output_decimator;

  localparam int DEPTH = 8;
  localparam int DEC   = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_en = 1'b0;
  logic [23:0] iv_din = '0;
  logic        i_din_valid = 1'b0;
  logic [15:0] ov_dout;
  logic        o_dout_valid;
  logic        i_dout_ready = 1'b0;
  logic        o_overflow;
  logic [3:0]  ov_level;

  int checks = 0;
  int failures = 0;

  logic [15:0] mq[$];
  int          ph = 0;
  bit          movf = 1'b0;
  bit          started = 1'b0;
  logic [15:0] popped[$];

  fir_output_decimator dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .iv_din(iv_din),
    .i_din_valid(i_din_valid), .ov_dout(ov_dout), .o_dout_valid(o_dout_valid),
    .i_dout_ready(i_dout_ready), .o_overflow(o_overflow), .ov_level(ov_level)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] conv(input logic [23:0] d);
    longint v;
    v = longint'($signed(d));
`ifdef FIR_DECIM_ROUND_EN
    v = (v + 128) >>> 8;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`else
    v = v >>> 8;
`endif
    return v[15:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model steps on each edge, then the DUT is compared against it.
  always @(posedge i_clk) begin
    bit pop, keep;
    int sz;
    if (o_dout_valid === 1'b1 && i_dout_ready) popped.push_back(ov_dout);
    if (i_rst) begin
      mq.delete();
      ph = 0;
      movf = 1'b0;
      started = 1'b1;
    end else begin
      sz   = mq.size();
      pop  = (sz > 0) && i_dout_ready;
      keep = i_en && i_din_valid && (ph == 0);
      if (pop) void'(mq.pop_front());
      if (keep) begin
        if (sz < DEPTH || pop) mq.push_back(conv(iv_din));
        else movf = 1'b1;
      end
      if (i_en && i_din_valid) ph = (ph + 1) % DEC;
    end
    #1;
    if (started) begin
      check("valid", 64'(o_dout_valid), 64'(mq.size() != 0));
      check("level", 64'(ov_level), 64'(mq.size()));
      check("overflow", 64'(o_overflow), 64'(movf));
      if (mq.size() != 0) check("dout", 64'(ov_dout), 64'(mq[0]));
    end
  end

  task automatic cyc(input bit rst, input bit en, input bit v, input logic [23:0] d, input bit r);
    @(negedge i_clk);
    i_rst = rst; i_en = en; i_din_valid = v; iv_din = d; i_dout_ready = r;
  endtask

  task automatic settle();
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset();
    cyc(1, 1, 1, 24'h0abc00, 1);
    cyc(1, 0, 0, 24'h0, 0);
    cyc(0, 0, 0, 24'h0, 0);
    settle();
    popped.delete();
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 24'h0, r);
  endtask

  task automatic conv_case(input string name, input logic [23:0] d, input logic [15:0] exp);
    popped.delete();
    cyc(0, 1, 1, d, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 24'h0, 1);
    idle(2, 1);
    settle();
    check({name, "_count"}, 64'(popped.size()), 64'(4 / DEC));
    if (popped.size() > 0) check(name, 64'(popped[0]), 64'(exp));
  endtask

  initial begin
    logic [23:0] specials[5];
    specials[0] = 24'h7fffff; specials[1] = 24'h800000; specials[2] = 24'h7fff80;
    specials[3] = 24'hffff7f; specials[4] = 24'h000080;

    // Reset state with a sample presented during reset.
    do_reset();
    check("rst_level", 64'(ov_level), 64'd0);
    check("rst_valid", 64'(o_dout_valid), 64'd0);
    check("rst_ovf", 64'(o_overflow), 64'd0);
    check("rst_dout", 64'(ov_dout), 64'd0);

    // Decimation: 1..12 keeps 1, 5, 9.
    for (int k = 1; k <= 12; k++) cyc(0, 1, 1, 24'(k << 8), 1);
    idle(3, 1);
    settle();
    check("decim_count", 64'(popped.size()), 64'd3);
    if (popped.size() == 3) begin
      check("decim_0", 64'(popped[0]), 64'd1);
      check("decim_1", 64'(popped[1]), 64'd5);
      check("decim_2", 64'(popped[2]), 64'd9);
    end

    // Conversion corner cases (phase is back at 0 after 12 samples).
`ifdef FIR_DECIM_ROUND_EN
    conv_case("conv_180", 24'h000180, 16'h0002);
`else
    conv_case("conv_180", 24'h000180, 16'h0001);
`endif
    conv_case("conv_7fff80", 24'h7fff80, 16'h7fff);
    conv_case("conv_ffff7f", 24'hffff7f, 16'hffff);

    // Overflow: 36 samples with no consumer.
    do_reset();
    for (int k = 1; k <= 36; k++) cyc(0, 1, 1, 24'(k << 8), 0);
    idle(1, 0);
    settle();
    check("ovf_level", 64'(ov_level), 64'd8);
    check("ovf_flag", 64'(o_overflow), 64'd1);
    popped.delete();
    idle(12, 1);
    settle();
    check("ovf_held", 64'(o_overflow), 64'd1);
    check("drain_count", 64'(popped.size()), 64'd8);
    for (int i = 0; i < 8 && i < popped.size(); i++)
      check("drain_val", 64'(popped[i]), 64'(1 + 4 * i));

    // Full FIFO with a simultaneous pop on a kept cycle.
    do_reset();
    for (int k = 1; k <= 32; k++) cyc(0, 1, 1, 24'(k << 8), 0);
    cyc(0, 1, 1, 24'h777700, 1);
    settle();
    check("fullpop_level", 64'(ov_level), 64'd8);
    check("fullpop_ovf", 64'(o_overflow), 64'd0);
    idle(10, 1);

    // Enable gating: valid without enable must not write or advance phase.
    do_reset();
    for (int k = 0; k < 10; k++) cyc(0, 0, 1, 24'(k << 12), 1);
    settle();
    check("gate_level", 64'(ov_level), 64'd0);
    cyc(0, 1, 1, 24'h123400, 1);
    settle();
    check("gate_valid", 64'(o_dout_valid), 64'd1);
    check("gate_dout", 64'(ov_dout), 64'h1234);
    idle(2, 1);

    // Reset mid-operation: level 5, phase 2, overflow set.
    do_reset();
    for (int k = 1; k <= 36; k++) cyc(0, 1, 1, 24'(k << 8), 0);
    idle(4, 1);
    cyc(0, 1, 1, 24'h010000, 0);
    cyc(0, 1, 1, 24'h020000, 0);
    settle();
    check("mid_level", 64'(ov_level), 64'd5);
    check("mid_ovf", 64'(o_overflow), 64'd1);
    cyc(1, 1, 1, 24'h555500, 1);
    settle();
    check("mid_rst_level", 64'(ov_level), 64'd0);
    check("mid_rst_valid", 64'(o_dout_valid), 64'd0);
    check("mid_rst_ovf", 64'(o_overflow), 64'd0);
    check("mid_rst_dout", 64'(ov_dout), 64'd0);
    cyc(0, 1, 1, 24'habcd00, 0);
    settle();
    check("post_rst_valid", 64'(o_dout_valid), 64'd1);
    check("post_rst_dout", 64'(ov_dout), 64'habcd);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      logic [23:0] d;
      d = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 4)] : 24'($urandom);
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) < 4));
    end
    idle(20, 1);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_output_decimator.md
FIR_OUTPUT_DECIMATOR -- requirements
Module: fir_output_decimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, signed input sample width.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, signed output sample width; DATA_WIDTH > OUT_WIDTH required.
REQ-003 SHALL have parameter DECIM, default 4, decimation factor, >= 1.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, power of two, >= 2.
REQ-005 SHALL have port i_clk  input  1  clock, all logic on rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_en  input  1  input-side enable; gates acceptance of iv_din/i_din_valid only.
REQ-008 SHALL have port iv_din  input  DATA_WIDTH  signed sample from filter output.
REQ-009 SHALL have port i_din_valid  input  1  sample qualifier; no backpressure to source.
REQ-010 SHALL have port ov_dout  output  OUT_WIDTH  signed FIFO head sample.
REQ-011 SHALL have port o_dout_valid  output  1  high when FIFO non-empty.
REQ-012 SHALL have port i_dout_ready  input  1  consumer ready; pop when o_dout_valid & i_dout_ready.
REQ-013 SHALL have port o_overflow  output  1  sticky flag, kept sample dropped on full FIFO.
REQ-014 SHALL have port ov_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL accept a sample on a cycle when i_en & i_din_valid; all other cycles leave phase counter and FIFO write side unchanged.
REQ-016 SHALL keep an accepted sample only when phase counter = 0; phase counter increments per accepted sample, wraps DECIM-1 -> 0; DECIM = 1 keeps every sample.
REQ-017 SHALL convert a kept sample to OUT_WIDTH by removing SHIFT = DATA_WIDTH-OUT_WIDTH LSBs (per Configuration).
REQ-018 SHALL write the converted sample into the FIFO in the accept cycle; earliest ov_dout/o_dout_valid update is the next rising edge (1-cycle latency).
REQ-019 SHALL present ov_dout = FIFO head, registered; ov_dout is don't-care while o_dout_valid low.
REQ-020 SHALL hold ov_dout and o_dout_valid stable until popped; i_dout_ready and pops are not gated by i_en.
REQ-021 SHALL, on FIFO empty with simultaneous kept write, not pop; o_dout_valid rises next cycle.
REQ-022 SHALL, on FIFO full with simultaneous pop, accept the write; level stays FIFO_DEPTH.
REQ-023 SHALL, on FIFO full without pop, drop the kept sample, set o_overflow, and still advance the phase counter.
REQ-024 SHALL hold o_overflow high until reset.
REQ-025 SHALL update ov_level each cycle: +1 on write only, -1 on pop only, unchanged on both/neither.
REQ-026 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, on i_rst high at a rising edge, clear phase counter, pointers, ov_level = 0, o_dout_valid = 0, o_overflow = 0, ov_dout = 0.
REQ-028 SHALL discard all FIFO contents and any sample presented in the reset cycle; reset has priority over i_en, i_din_valid, i_dout_ready.
REQ-029 SHALL keep the first accepted sample after reset release (phase 0).

Configuration
REQ-030 SHALL, with macro FIR_DECIM_ROUND_EN defined, add 2^(SHIFT-1) before shifting and saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-031 SHALL, without FIR_DECIM_ROUND_EN, arithmetic-shift right by SHIFT (floor truncation), no saturation logic.

Verification (defaults: 24/16/4/8)
REQ-032 SHALL cover decimation: 12 consecutive valid samples 1..12 (<<8), ready=1 -> outputs 1, 5, 9 only, each 1 cycle after its input.
REQ-033 SHALL cover conversion: kept input 0x000180 -> 0x0001 without macro, 0x0002 with; kept input 0x7FFF80 -> 0x7FFF in both builds; 0xFFFF7F -> 0xFFFF without macro, 0xFFFF with.
REQ-034 SHALL cover overflow: ready=0, 36 valid samples -> ov_level = 8, 9th kept sample dropped, o_overflow = 1 and held after ready returns; drain yields the first 8 kept values in order.
REQ-035 SHALL cover full with simultaneous pop: FIFO full, ready=1 on a kept-sample cycle -> level stays 8, o_overflow stays 0.
REQ-036 SHALL cover gating: i_din_valid=1, i_en=0 for 10 cycles -> no writes, phase unchanged; i_en=1 resumes with next sample kept.
REQ-037 SHALL cover reset mid-operation: level 5, phase 2, o_overflow=1, assert i_rst 1 cycle -> all outputs 0, next accepted sample kept and output 1 cycle later.
